vga_timing_gen: RTL and testbench

- Upstream raster timing stage for the VGA output path. Derives the pixel rate from the 50 MHz board clock and generates hsync, vsync, blanking, data-enable and pixel coordinates.
- The colour-pattern/pixel stage consumes these outputs directly, so it needs no counters of its own.
- All outputs are registered and mutually aligned. They are qualified by a one-cycle pixel-enable strobe.

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides the board clock down to the pixel rate and
// produces registered, mutually aligned sync/blank/DE/coordinate outputs.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_pix_en,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_hblank,
    output logic        o_vblank,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_line_start,
    output logic        o_frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    // Sync bounds are inclusive so a zero back porch with a 4096 total still fits.
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [11:0]       h_cnt, v_cnt;
    logic [11:0]       h_nxt, v_nxt;
    logic              tick;
    logic              h_act, v_act, h_syn, v_syn;

    assign tick = (div == DIV_LAST);

    // PRIME presents (0,0) without advancing; RUN steps one pixel per tick.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (state == RUN) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
            end else begin
                h_nxt = h_cnt + 12'd1;
            end
        end
    end

    assign h_act = (h_nxt < H_ACT);
    assign v_act = (v_nxt < V_ACT);
    assign h_syn = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
    assign v_syn = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= PRIME;
            div           <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_pix_en      <= 1'b0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_hblank      <= 1'b0;
            o_vblank      <= 1'b0;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            div           <= tick ? '0 : div + DIV_W'(1);
            o_pix_en      <= tick;
            o_line_start  <= tick && (h_nxt == '0);
            o_frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
            if (tick) begin
                state    <= RUN;
                h_cnt    <= h_nxt;
                v_cnt    <= v_nxt;
                o_hsync  <= h_syn ? SYNC_POL : ~SYNC_POL;
                o_vsync  <= v_syn ? SYNC_POL : ~SYNC_POL;
                o_hblank <= ~h_act;
                o_vblank <= ~v_act;
                o_de     <= h_act && v_act;
                o_x      <= (h_act && v_act) ? h_nxt : '0;
                o_y      <= (h_act && v_act) ? v_nxt : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size instance plus two tiny rasters so
// whole frames, double wraps and both sync polarities fit in a short run.
module tb_vga_timing_gen;
    typedef struct packed {
        logic pe, hs, vs, hb, vb, de;
        logic [11:0] x, y;
        logic ls, fs;
    } vo_t;

    typedef struct {
        int    k;
        vo_t   exp;
        string nm;
    } vec_t;

    logic clk, rst_n;
    logic [2:0] pe, hs, vs, hb, vb, de, ls, fs;
    logic [2:0][11:0] x, y;
    int k;
    int n_vec, n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since the most recent reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else        k <= k + 1;

    vga_timing_gen u_a (
        .i_clk(clk), .i_rst_n(rst_n), .o_pix_en(pe[0]), .o_hsync(hs[0]), .o_vsync(vs[0]),
        .o_hblank(hb[0]), .o_vblank(vb[0]), .o_de(de[0]), .o_x(x[0]), .o_y(y[0]),
        .o_line_start(ls[0]), .o_frame_start(fs[0]));

    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .o_pix_en(pe[1]), .o_hsync(hs[1]), .o_vsync(vs[1]),
        .o_hblank(hb[1]), .o_vblank(vb[1]), .o_de(de[1]), .o_x(x[1]), .o_y(y[1]),
        .o_line_start(ls[1]), .o_frame_start(fs[1]));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .o_pix_en(pe[2]), .o_hsync(hs[2]), .o_vsync(vs[2]),
        .o_hblank(hb[2]), .o_vblank(vb[2]), .o_de(de[2]), .o_x(x[2]), .o_y(y[2]),
        .o_line_start(ls[2]), .o_frame_start(fs[2]));

    // Closed-form reference: the j-th tick after release shows pixel j-1 in raster order.
    function automatic vo_t model(int kk, bit in_rst, int dv, int ha, int hf, int hsw, int hbp,
                                  int va, int vf, int vsw, int vbp, bit pol);
        vo_t r;
        int p, h, v, ht, vt;
        r = '0;
        r.hs = ~pol;
        r.vs = ~pol;
        if (in_rst || kk < dv) return r;
        ht = ha + hf + hsw + hbp;
        vt = va + vf + vsw + vbp;
        p = kk / dv - 1;
        h = p % ht;
        v = (p / ht) % vt;
        r.pe = (kk % dv == 0);
        r.hb = (h >= ha);
        r.vb = (v >= va);
        r.de = !r.hb && !r.vb;
        r.x  = r.de ? 12'(h) : 12'd0;
        r.y  = r.de ? 12'(v) : 12'd0;
        r.hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
        r.vs = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
        r.ls = r.pe && (h == 0);
        r.fs = r.ls && (v == 0);
        return r;
    endfunction

    function automatic vo_t expv(int i);
        case (i)
            0:       return model(k, !rst_n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            1:       return model(k, !rst_n, 3, 8, 2, 3, 2, 5, 1, 2, 2, 1'b0);
            default: return model(k, !rst_n, 1, 8, 2, 3, 2, 5, 1, 2, 2, 1'b1);
        endcase
    endfunction

    function automatic vo_t act(int i);
        vo_t r;
        r = {pe[i], hs[i], vs[i], hb[i], vb[i], de[i], x[i], y[i], ls[i], fs[i]};
        return r;
    endfunction

    function automatic vo_t mk(bit pe_, bit hs_, bit vs_, bit hb_, bit vb_, bit de_,
                               int x_, int y_, bit ls_, bit fs_);
        vo_t r;
        r = {pe_, hs_, vs_, hb_, vb_, de_, 12'(x_), 12'(y_), ls_, fs_};
        return r;
    endfunction

    task automatic cmp(string nm, vo_t a, vo_t e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s k=%0d got pe%b hs%b vs%b hb%b vb%b de%b x%0d y%0d ls%b fs%b want pe%b hs%b vs%b hb%b vb%b de%b x%0d y%0d ls%b fs%b",
                     nm, k, a.pe, a.hs, a.vs, a.hb, a.vb, a.de, a.x, a.y, a.ls, a.fs,
                     e.pe, e.hs, e.vs, e.hb, e.vb, e.de, e.x, e.y, e.ls, e.fs);
        end
    endtask

    task automatic cmpi(string nm, int a, int e);
        n_vec++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    task automatic check_all();
        cmp("model_a", act(0), expv(0));
        cmp("model_b", act(1), expv(1));
        cmp("model_c", act(2), expv(2));
    endtask

    task automatic run(int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    vec_t tab[$];
    vo_t  a, rst_a;
    int   ti, s, de_cnt, hb_cnt, hs_cnt, hs_first, ls_next, hs_cyc;
    int   found, cyc, last_b, last_c, per_b, per_c, len, hold;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        rst_a = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tab.push_back('{k: 1,    exp: mk(0, 1, 1, 0, 0, 0, 0,   0, 0, 0), nm: "pre_tick"});
        tab.push_back('{k: 2,    exp: mk(1, 1, 1, 0, 0, 1, 0,   0, 1, 1), nm: "first_pix"});
        tab.push_back('{k: 3,    exp: mk(0, 1, 1, 0, 0, 1, 0,   0, 0, 0), nm: "hold_between"});
        tab.push_back('{k: 4,    exp: mk(1, 1, 1, 0, 0, 1, 1,   0, 0, 0), nm: "second_pix"});
        tab.push_back('{k: 1280, exp: mk(1, 1, 1, 0, 0, 1, 639, 0, 0, 0), nm: "last_active_col"});
        tab.push_back('{k: 1282, exp: mk(1, 1, 1, 1, 0, 0, 0,   0, 0, 0), nm: "front_porch"});
        tab.push_back('{k: 1312, exp: mk(1, 1, 1, 1, 0, 0, 0,   0, 0, 0), nm: "pre_hsync"});
        tab.push_back('{k: 1314, exp: mk(1, 0, 1, 1, 0, 0, 0,   0, 0, 0), nm: "hsync_start"});
        tab.push_back('{k: 1315, exp: mk(0, 0, 1, 1, 0, 0, 0,   0, 0, 0), nm: "hsync_hold"});
        tab.push_back('{k: 1504, exp: mk(1, 0, 1, 1, 0, 0, 0,   0, 0, 0), nm: "hsync_last"});
        tab.push_back('{k: 1506, exp: mk(1, 1, 1, 1, 0, 0, 0,   0, 0, 0), nm: "back_porch"});
        tab.push_back('{k: 1600, exp: mk(1, 1, 1, 1, 0, 0, 0,   0, 0, 0), nm: "line_end"});
        tab.push_back('{k: 1602, exp: mk(1, 1, 1, 0, 0, 1, 0,   1, 1, 0), nm: "line1_start"});
        tab.push_back('{k: 1604, exp: mk(1, 1, 1, 0, 0, 1, 1,   1, 0, 0), nm: "line1_px1"});

        // Reset held: everything at reset level.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_all();
            cmp("rst_hold_a", act(0), rst_a);
        end

        // First line of the default raster: table points plus strobe statistics.
        rst_n = 1'b1;
        ti = 0; s = 0; de_cnt = 0; hb_cnt = 0; hs_cnt = 0; hs_first = -1; ls_next = -1; hs_cyc = 0;
        for (int c = 1; c <= 1610; c++) begin
            @(negedge clk);
            check_all();
            a = act(0);
            if (ti < tab.size() && tab[ti].k == k) begin
                cmp(tab[ti].nm, a, tab[ti].exp);
                ti++;
            end
            if (!a.hs) hs_cyc++;
            if (a.pe) begin
                if (s < 800) begin
                    if (a.de) de_cnt++;
                    if (a.hb) hb_cnt++;
                    if (!a.hs) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = s;
                    end
                end
                if (s > 0 && a.ls && ls_next < 0) ls_next = s;
                s++;
            end
        end
        cmpi("table_entries_reached", ti, tab.size());
        cmpi("de_strobes", de_cnt, 640);
        cmpi("hblank_strobes", hb_cnt, 160);
        cmpi("hsync_strobes", hs_cnt, 96);
        cmpi("hsync_first_strobe", hs_first, 656);
        cmpi("hsync_cycles", hs_cyc, 192);
        cmpi("line_start_period", ls_next, 800);

        // Mid-frame asynchronous reset on the small CLK_DIV=3 raster at (4,3).
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            check_all();
            if (k == 150) found = 1;
        end
        cmpi("reach_mid_frame", found, 1);
        cmp("mid_frame_pos_b", act(1), mk(1, 1, 1, 0, 0, 1, 4, 3, 0, 0));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 cmp("async_rst_b", act(1), mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cmp("async_rst_c", act(2), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            check_all();
            if (pe[1]) found = 1;
        end
        cmpi("post_reset_strobe_b", found, 1);
        cmp("post_reset_pix_b", act(1), mk(1, 1, 1, 0, 0, 1, 0, 0, 1, 1));

        // Frame period: 150 pixels -> 450 cycles at CLK_DIV=3, 150 at CLK_DIV=1.
        last_b = -1; last_c = -1; per_b = 0; per_c = 0;
        for (cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            check_all();
            if (fs[1]) begin
                if (last_b >= 0) per_b = cyc - last_b;
                last_b = cyc;
            end
            if (fs[2]) begin
                if (last_c >= 0) per_c = cyc - last_c;
                last_c = cyc;
            end
        end
        cmpi("frame_period_b", per_b, 450);
        cmpi("frame_period_c", per_c, 150);

        // Random run lengths and reset pulses, synchronous-looking or mid-cycle.
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, 1200);
            run(len);
            if ($urandom_range(0, 1) == 0) begin
                rst_n = 1'b0;
                hold = $urandom_range(1, 3);
                run(hold);
            end else begin
                @(posedge clk);
                #($urandom_range(1, 4)) rst_n = 1'b0;
                run(1);
            end
            rst_n = 1'b1;
        end
        run(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
